add_header_shift: RTL and testbench
===================================

// Module: add_header_shift
// PURPOSE
//  Parametrised header inserter for 512b-class packet streams. Consumes one meta word per packet and
//  prepends it in the lowest HDR_W bits (bytes 0..HB-1) of beat 0, shifting payload up by HB bytes.
//  Residual top bytes carry into the next beat. An extra tail beat is emitted when the shift overflows.
//  Sits between the packet builder and the network TX path. Generalises the fixed 32b header inserter.
// PARAMETERS
//  DATA_W  512  data bus width in bits; multiple of 8; KB = DATA_W/8 keep bits
//  HDR_W   32   header width in bits; multiple of 8, 8 <= HDR_W < DATA_W; HB = HDR_W/8
// PORTS
//  clock                  in   1       single clock, rising edge
//  reset                  in   1       asynchronous, active-high
//  io_in_meta_valid/ready in/out 1     meta handshake
//  io_in_meta_bits        in   HDR_W   header value for the next packet
//  io_in_data_valid/ready in/out 1     payload handshake
//  io_in_data_bits_data   in   DATA_W  payload beat
//  io_in_data_bits_keep   in   KB      byte enables (contiguous from bit 0 on last beat)
//  io_in_data_bits_last   in   1       last beat of packet
//  io_out_data_valid/ready out/in 1    output handshake
//  io_out_data_bits_data/keep/last out DATA_W/KB/1   shifted stream
//  io_stat_pkts, io_stat_tail_beats  out 32  (only with ADD_HEADER_STATS_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out data/keep/last=0, residual regs=0, counters=0; in readies=0.
//  - Single output register; slot_free = !out_valid || out_ready. Latency 1 cycle in-fire -> out_valid.
//  - out data/keep/last held stable while out_valid && !out_ready.
//  - FSM IDLE: meta_ready = data_valid && slot_free; data_ready = meta_valid && slot_free (both fire
//    together). Out = {data[DATA_W-HDR_W-1:0], meta}, keep = {keep[KB-HB-1:0], {HB{1}}}.
//  - FSM BODY: data_ready = slot_free; meta_ready=0. Out = {data[DATA_W-HDR_W-1:0], res_data},
//    keep = {keep[KB-HB-1:0], res_keep}.
//  - Every accepted beat: res_data <= data[DATA_W-1 -: HDR_W], res_keep <= keep[KB-1 -: HB].
//  - Accepted beat with last=1: if |keep[KB-1 -: HB] -> out_last=0, go TAIL; else out_last=1, go IDLE.
//    Otherwise go/stay BODY, out_last=0. Single-beat packets take the IDLE rule then this rule.
//  - TAIL: both in readies 0; when slot_free emit {0, res_data}, keep {0, res_keep}, last=1 -> IDLE.
//  - Data arriving before meta (or vice versa) waits; no output until both are valid.
//  - Readies depend on valids, never the reverse; no comb path out_ready -> out_valid.
//  - Reset mid-packet: partial packet discarded, out_valid drops immediately, FSM resumes at IDLE.
// CONFIGURATION
//  ADD_HEADER_STATS_EN defined: io_stat_pkts += 1 per out beat fired with last=1; io_stat_tail_beats
//    += 1 per TAIL beat fired; both 32b, wrap at 2^32, cleared by reset.
//  Not defined: stat ports and counters absent; datapath identical.
// STRUCTURE
//  Package add_header_pkg: state_e {IDLE, BODY, TAIL}; functions hdr_bytes(HDR_W), keep_bits(DATA_W).
//  Sub-module add_header_out_stage: parametrised valid/data/keep/last output register with slot_free.
//  Static elaboration checks on HDR_W%8, DATA_W%8, HDR_W<DATA_W.
// TESTING (DATA_W=512, HDR_W=32)
//  1 meta 0x1111; beats {0x01,keep all-1,last 0},{0x02,all-1,last 1} -> out 0x1_00001111 keep all-1 l0;
//    0x2_00000000 keep all-1 l0; tail data 0 keep 0xF l1.
//  2 meta 0x1111; beats 0x01 all-1 l0, 0x02 keep 0x0FFF_FFFF_FFFF_FFFF l1 -> 2 out beats, 2nd keep
//    all-1 last 1, no tail beat.
//  3 two data beats presented 50ns before meta -> no out until meta; then same output as scenario 1.
//  4 out_ready low 10 cycles mid-packet, 4-beat packet -> in_data_ready low, out held stable,
//    all beats delivered in order, none lost or duplicated.
//  5 reset pulse after beat 1 of 3 -> out_valid 0 same cycle; next packet meta 0x2222 output intact.
//  6 ADD_HEADER_STATS_EN: run scenarios 1+2 -> io_stat_pkts=2, io_stat_tail_beats=1; without macro builds.

Source files
------------

// File: rtl/add_header_pkg.sv
// Shared types and sizing helpers for the header inserter.
// Used by add_header_shift and add_header_out_stage.
package add_header_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    TAIL
  } state_e;

  function automatic int hdr_bytes(input int hdr_w);
    return hdr_w / 8;
  endfunction

  function automatic int keep_bits(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/add_header_out_stage.sv
// Single output register slice: valid/data/keep/last with slot_free.
// Contents hold while valid && !ready.
module add_header_out_stage #(
  parameter int DATA_W = 512,
  parameter int KB     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KB-1:0]     keep_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KB-1:0]     keep_o,
  output logic              last_o,
  output logic              slot_free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q;
  logic [KB-1:0]     keep_q;
  logic              last_q;

  assign slot_free_o = !valid_q || ready_i;
  assign valid_d     = load_i || (valid_q && !ready_i);

  // Valid flag: set on load, cleared once the beat is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload: captured only on load so it stays stable under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      keep_q <= keep_i;
      last_q <= last_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/add_header_shift.sv
// Prepends one meta word per packet, shifting payload up by HB bytes.
// Optional counters: define ADD_HEADER_STATS_EN.
module add_header_shift
  import add_header_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int HDR_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_meta_valid,
  output logic                     io_in_meta_ready,
  input  logic [HDR_W-1:0]         io_in_meta_bits,
  input  logic                     io_in_data_valid,
  output logic                     io_in_data_ready,
  input  logic [DATA_W-1:0]        io_in_data_bits_data,
  input  logic [DATA_W/8-1:0]      io_in_data_bits_keep,
  input  logic                     io_in_data_bits_last,
  output logic                     io_out_data_valid,
  input  logic                     io_out_data_ready,
  output logic [DATA_W-1:0]        io_out_data_bits_data,
  output logic [DATA_W/8-1:0]      io_out_data_bits_keep,
  output logic                     io_out_data_bits_last
`ifdef ADD_HEADER_STATS_EN
  ,
  output logic [31:0]              io_stat_pkts,
  output logic [31:0]              io_stat_tail_beats
`endif
);

  localparam int HB = hdr_bytes(HDR_W);
  localparam int KB = keep_bits(DATA_W);

  if (HDR_W % 8 != 0) begin : g_bad_hdr_w
    $error("HDR_W must be a multiple of 8");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (HDR_W < 8 || HDR_W >= DATA_W) begin : g_bad_ratio
    $error("HDR_W must satisfy 8 <= HDR_W < DATA_W");
  end

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  res_data_q;
  logic [HB-1:0]     res_keep_q;

  logic              slot_free;
  logic              beat_fire;
  logic              load;
  logic              ovf;
  logic [DATA_W-1:0] nxt_data;
  logic [KB-1:0]     nxt_keep;
  logic              nxt_last;

  // Top HB bytes of the incoming beat spill into the next output beat.
  assign ovf = |io_in_data_bits_keep[KB-1 -: HB];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: advance on accepted beats and emitted tails.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, BODY: begin
        if (beat_fire) begin
          if (!io_in_data_bits_last) state_d = BODY;
          else if (ovf)              state_d = TAIL;
          else                       state_d = IDLE;
        end
      end
      TAIL: begin
        if (slot_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes and the shifted beat to load.
  always_comb begin
    io_in_meta_ready = 1'b0;
    io_in_data_ready = 1'b0;
    beat_fire        = 1'b0;
    load             = 1'b0;
    nxt_data         = '0;
    nxt_keep         = '0;
    nxt_last         = 1'b0;
    unique case (state_q)
      IDLE: begin
        io_in_meta_ready = io_in_data_valid && slot_free && !reset;
        io_in_data_ready = io_in_meta_valid && slot_free && !reset;
        beat_fire = io_in_meta_valid && io_in_data_valid && slot_free;
        load      = beat_fire;
        nxt_data  = {io_in_data_bits_data[DATA_W-HDR_W-1:0], io_in_meta_bits};
        nxt_keep  = {io_in_data_bits_keep[KB-HB-1:0], {HB{1'b1}}};
        nxt_last  = io_in_data_bits_last && !ovf;
      end
      BODY: begin
        io_in_data_ready = slot_free && !reset;
        beat_fire = io_in_data_valid && slot_free;
        load      = beat_fire;
        nxt_data  = {io_in_data_bits_data[DATA_W-HDR_W-1:0], res_data_q};
        nxt_keep  = {io_in_data_bits_keep[KB-HB-1:0], res_keep_q};
        nxt_last  = io_in_data_bits_last && !ovf;
      end
      TAIL: begin
        load     = slot_free;
        nxt_data = {{(DATA_W-HDR_W){1'b0}}, res_data_q};
        nxt_keep = {{(KB-HB){1'b0}}, res_keep_q};
        nxt_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Residual: the bytes pushed off the top of each accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_data_q <= '0;
      res_keep_q <= '0;
    end else if (beat_fire) begin
      res_data_q <= io_in_data_bits_data[DATA_W-1 -: HDR_W];
      res_keep_q <= io_in_data_bits_keep[KB-1 -: HB];
    end
  end

  add_header_out_stage #(
    .DATA_W (DATA_W),
    .KB     (KB)
  ) u_out (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (load),
    .data_i      (nxt_data),
    .keep_i      (nxt_keep),
    .last_i      (nxt_last),
    .ready_i     (io_out_data_ready),
    .valid_o     (io_out_data_valid),
    .data_o      (io_out_data_bits_data),
    .keep_o      (io_out_data_bits_keep),
    .last_o      (io_out_data_bits_last),
    .slot_free_o (slot_free)
  );

`ifdef ADD_HEADER_STATS_EN
  logic        tail_q;
  logic [31:0] pkts_q;
  logic [31:0] tails_q;
  logic        out_fire;

  assign out_fire = io_out_data_valid && io_out_data_ready;

  // Counters: packets and tail beats leaving the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tail_q  <= 1'b0;
      pkts_q  <= '0;
      tails_q <= '0;
    end else begin
      if (load) tail_q <= (state_q == TAIL);
      if (out_fire && io_out_data_bits_last) pkts_q <= pkts_q + 32'd1;
      if (out_fire && tail_q) tails_q <= tails_q + 32'd1;
    end
  end

  assign io_stat_pkts       = pkts_q;
  assign io_stat_tail_beats = tails_q;
`endif

endmodule

// File: tb/tb_add_header_shift.sv
// Bench for add_header_shift (DATA_W=512, HDR_W=32) with a
// byte-stream reference model feeding a scoreboard queue.
module tb_add_header_shift;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic         clock;
  logic         reset;
  logic         io_in_meta_valid;
  logic         io_in_meta_ready;
  logic [31:0]  io_in_meta_bits;
  logic         io_in_data_valid;
  logic         io_in_data_ready;
  logic [511:0] io_in_data_bits_data;
  logic [63:0]  io_in_data_bits_keep;
  logic         io_in_data_bits_last;
  logic         io_out_data_valid;
  logic         io_out_data_ready;
  logic [511:0] io_out_data_bits_data;
  logic [63:0]  io_out_data_bits_keep;
  logic         io_out_data_bits_last;
`ifdef ADD_HEADER_STATS_EN
  logic [31:0]  io_stat_pkts;
  logic [31:0]  io_stat_tail_beats;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  beat_t        exp_q[$];
  logic [511:0] pd[$];
  logic [63:0]  pk[$];

  add_header_shift #(
    .DATA_W (512),
    .HDR_W  (32)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_in_meta_valid      (io_in_meta_valid),
    .io_in_meta_ready      (io_in_meta_ready),
    .io_in_meta_bits       (io_in_meta_bits),
    .io_in_data_valid      (io_in_data_valid),
    .io_in_data_ready      (io_in_data_ready),
    .io_in_data_bits_data  (io_in_data_bits_data),
    .io_in_data_bits_keep  (io_in_data_bits_keep),
    .io_in_data_bits_last  (io_in_data_bits_last),
    .io_out_data_valid     (io_out_data_valid),
    .io_out_data_ready     (io_out_data_ready),
    .io_out_data_bits_data (io_out_data_bits_data),
    .io_out_data_bits_keep (io_out_data_bits_keep),
    .io_out_data_bits_last (io_out_data_bits_last)
`ifdef ADD_HEADER_STATS_EN
    ,
    .io_stat_pkts          (io_stat_pkts),
    .io_stat_tail_beats    (io_stat_tail_beats)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: header bytes then every payload byte as one stream, cut into 64B beats.
  function automatic void build_expected(input logic [31:0] meta);
    int n = pd.size();
    int tot = 64 * (n + 1);
    int nvalid;
    int nbeats;
    logic [7:0] by[];
    bit kb[];
    beat_t e;
    by = new[tot];
    kb = new[tot];
    for (int i = 0; i < tot; i++) begin
      by[i] = 8'h00;
      kb[i] = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      by[j] = meta[8*j +: 8];
      kb[j] = 1'b1;
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 64; j++) begin
        by[4 + 64*i + j] = pd[i][8*j +: 8];
        kb[4 + 64*i + j] = pk[i][j];
      end
    nvalid = 4 + 64 * (n - 1) + $countones(pk[n-1]);
    nbeats = (nvalid + 63) / 64;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 64; j++) begin
        e.d[8*j +: 8] = by[64*b + j];
        e.k[j]        = kb[64*b + j];
      end
      e.l = (b == nbeats - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] keep_n(input int k);
    logic [63:0] one = 64'd1;
    if (k >= 64) return '1;
    return (one << k) - 64'd1;
  endfunction

  // Scoreboard: every output handshake is popped and compared.
  always @(negedge clock) begin
    if (!reset && io_out_data_valid && io_out_data_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_extra: got data=%h keep=%h last=%b, required no beat",
                 io_out_data_bits_data, io_out_data_bits_keep, io_out_data_bits_last);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if ({io_out_data_bits_data, io_out_data_bits_keep, io_out_data_bits_last}
            !== {e.d, e.k, e.l}) begin
          n_fail++;
          $display("FAIL out_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                   io_out_data_bits_data, io_out_data_bits_keep, io_out_data_bits_last,
                   e.d, e.k, e.l);
        end
      end
    end
  end

  task automatic send_pkt(input logic [31:0] meta, input int meta_delay);
    int n = pd.size();
    int t;
    bit acc;
    build_expected(meta);
    for (int i = 0; i < n; i++) begin
      io_in_data_valid     = 1'b1;
      io_in_data_bits_data = pd[i];
      io_in_data_bits_keep = pk[i];
      io_in_data_bits_last = (i == n - 1);
      if (i == 0) begin
        io_in_meta_bits = meta;
        for (int c = 0; c < meta_delay; c++) begin
          @(negedge clock);
          n_cmp++;
          if (io_out_data_valid !== 1'b0 || io_in_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_meta: got out_valid=%b data_ready=%b, required 0 0",
                     io_out_data_valid, io_in_data_ready);
          end
          @(posedge clock); #1;
        end
        io_in_meta_valid = 1'b1;
      end
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clock);
        acc = io_in_data_valid && io_in_data_ready;
        t++;
        @(posedge clock); #1;
      end
      if (!acc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no accept of beat %0d, required accept", i);
      end
      io_in_meta_valid = 1'b0;
    end
    io_in_data_valid     = 1'b0;
    io_in_data_bits_last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || io_out_data_valid) && t < 1000) begin
      @(posedge clock); #1;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || io_out_data_valid) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d pending out_valid=%b, required 0 0",
               name, exp_q.size(), io_out_data_valid);
    end
  endtask

  task automatic pulse_reset();
    io_in_meta_valid = 1'b0;
    io_in_data_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_in_meta_valid = 1'b1;
    io_in_data_valid = 1'b1;
    io_in_meta_bits = 32'hDEAD_BEEF;
    io_in_data_bits_data = '1;
    io_in_data_bits_keep = '1;
    io_in_data_bits_last = 1'b1;
    io_out_data_ready = 1'b1;
    #3;
    @(posedge clock); #1;
    n_cmp++;
    if (io_out_data_valid !== 1'b0 || io_out_data_bits_data !== '0 ||
        io_out_data_bits_keep !== '0 || io_out_data_bits_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b keep=%h last=%b, required 0 0 0",
               io_out_data_valid, io_out_data_bits_keep, io_out_data_bits_last);
    end
    n_cmp++;
    if (io_in_meta_ready !== 1'b0 || io_in_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got meta_ready=%b data_ready=%b, required 0 0",
               io_in_meta_ready, io_in_data_ready);
    end
`ifdef ADD_HEADER_STATS_EN
    n_cmp++;
    if (io_stat_pkts !== 32'd0 || io_stat_tail_beats !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d %0d, required 0 0",
               io_stat_pkts, io_stat_tail_beats);
    end
`endif
    io_in_meta_valid = 1'b0;
    io_in_data_valid = 1'b0;
    io_in_data_bits_last = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic load_s1();
    pd.delete(); pk.delete();
    pd.push_back(512'h01); pk.push_back('1);
    pd.push_back(512'h02); pk.push_back('1);
  endtask

  task automatic load_s2();
    pd.delete(); pk.delete();
    pd.push_back(512'h01); pk.push_back('1);
    pd.push_back(512'h02); pk.push_back(64'h0FFF_FFFF_FFFF_FFFF);
  endtask

  task automatic test_tail_beat();
    load_s1();
    send_pkt(32'h0000_1111, 0);
    wait_drain("tail_beat");
  endtask

  task automatic test_no_tail();
    load_s2();
    send_pkt(32'h0000_1111, 0);
    wait_drain("no_tail");
  endtask

  task automatic test_data_before_meta();
    load_s1();
    send_pkt(32'h0000_1111, 5);
    wait_drain("data_first");
  endtask

  task automatic test_backpressure();
    beat_t snap;
    pd.delete(); pk.delete();
    for (int i = 0; i < 4; i++) begin
      pd.push_back(rnd512());
      pk.push_back(i == 3 ? keep_n(62) : '1);
    end
    fork
      send_pkt(32'hA5A5_0F0F, 0);
      begin
        repeat (2) @(posedge clock);
        #1 io_out_data_ready = 1'b0;
        @(negedge clock);
        snap = {io_out_data_bits_data, io_out_data_bits_keep, io_out_data_bits_last};
        n_cmp++;
        if (io_out_data_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_valid: got %b, required 1", io_out_data_valid);
        end
        for (int c = 0; c < 10; c++) begin
          @(negedge clock);
          n_cmp++;
          if ({io_out_data_bits_data, io_out_data_bits_keep, io_out_data_bits_last}
              !== snap || io_out_data_valid !== 1'b1 || io_in_data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got keep=%h v=%b data_ready=%b, required keep=%h v=1 data_ready=0",
                     io_out_data_bits_keep, io_out_data_valid, io_in_data_ready, snap.k);
          end
        end
        @(posedge clock); #1;
        io_out_data_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid_packet();
    io_in_meta_bits      = 32'h0000_3333;
    io_in_meta_valid     = 1'b1;
    io_in_data_valid     = 1'b1;
    io_in_data_bits_data = rnd512();
    io_in_data_bits_keep = '1;
    io_in_data_bits_last = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (io_in_data_ready !== 1'b1 || io_in_meta_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accept: got data_ready=%b meta_ready=%b, required 1 1",
               io_in_data_ready, io_in_meta_ready);
    end
    @(posedge clock); #1;
    io_in_meta_valid = 1'b0;
    io_in_data_bits_data = rnd512();
    n_cmp++;
    if (io_out_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_valid: got %b, required 1", io_out_data_valid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (io_out_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got out_valid=%b, required 0", io_out_data_valid);
    end
    io_in_data_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    pd.delete(); pk.delete();
    pd.push_back(rnd512()); pk.push_back('1);
    pd.push_back(rnd512()); pk.push_back(keep_n(20));
    send_pkt(32'h0000_2222, 0);
    wait_drain("after_reset");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 8; p++) begin
      int n = $urandom_range(1, 4);
      pd.delete(); pk.delete();
      for (int i = 0; i < n; i++) begin
        pd.push_back(rnd512());
        pk.push_back(i == n - 1 ? keep_n($urandom_range(1, 64)) : '1);
      end
      send_pkt($urandom, 0);
    end
    pd.delete(); pk.delete();
    pd.push_back(rnd512()); pk.push_back(keep_n(60));
    send_pkt(32'h1357_9BDF, 0);
    pd.delete(); pk.delete();
    pd.push_back(rnd512()); pk.push_back(keep_n(61));
    send_pkt(32'h2468_ACE0, 0);
    wait_drain("back_to_back");
  endtask

`ifdef ADD_HEADER_STATS_EN
  task automatic test_stats();
    pulse_reset();
    load_s1();
    send_pkt(32'h0000_1111, 0);
    wait_drain("stats_s1");
    load_s2();
    send_pkt(32'h0000_1111, 0);
    wait_drain("stats_s2");
    n_cmp++;
    if (io_stat_pkts !== 32'd2 || io_stat_tail_beats !== 32'd1) begin
      n_fail++;
      $display("FAIL stats: got pkts=%0d tails=%0d, required 2 1",
               io_stat_pkts, io_stat_tail_beats);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tail_beat();
    test_no_tail();
    test_data_before_meta();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
`ifdef ADD_HEADER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
